// File: rtl/lmx2492_spi_pkg.sv
// Shared constants, frame layout and FSM state encoding for the LMX2492 SPI master.
package lmx2492_spi_pkg;

  localparam int unsigned WORD_W    = 25;
  localparam int unsigned FRAME_W   = 24;
  localparam int unsigned VALID_BIT = 24;
  localparam int unsigned RW_BIT    = 23;
  localparam int unsigned ADDR_MSB  = 22;
  localparam int unsigned ADDR_LSB  = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned BIT_W     = $clog2(FRAME_W);

  // 24-bit over-the-wire frame, MSB first
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SETUP, SHIFT, HOLD, GAP} state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lmx2492_spi_master_if.sv
// FIFO-side, SPI-side and readback signals of the LMX2492 SPI master.
interface lmx2492_spi_master_if;
  import lmx2492_spi_pkg::*;

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [WORD_W-1:0] fifo_dout;
  logic              spi_csb;
  logic              spi_sck;
  logic              spi_sdi;
  logic              spi_muxout;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [7:0]        drop_cnt;

  modport master (
    input  fifo_empty, fifo_dout, spi_muxout,
    output fifo_rd_en, spi_csb, spi_sck, spi_sdi, rd_valid, rd_addr, rd_data, busy, drop_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, spi_muxout,
    input  fifo_rd_en, spi_csb, spi_sck, spi_sdi, rd_valid, rd_addr, rd_data, busy, drop_cnt
  );

endinterface

// File: rtl/lmx2492_muxout_sync.sv
// Two-flop synchroniser bringing the asynchronous MUXout readback line into read_clk.
module lmx2492_muxout_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/lmx2492_spi_master.sv
// Pops command words from the LMX2492 FIFO and shifts them out on the 3-wire SPI,
// capturing the MUXout readback byte for read frames.
module lmx2492_spi_master
  import lmx2492_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned FRAME_GAP = 4
) (
  input  logic                 read_clk,
  input  logic                 sys_rst,
  lmx2492_spi_master_if.master bus
);

  localparam int unsigned CNT_MAX = max_u(max_u(2 * CLK_DIV, CS_SETUP), max_u(CS_HOLD, FRAME_GAP));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  frame_t             frame_q, frame_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic               csb_q, csb_d, sck_q, sck_d, sdi_q, sdi_d;
  logic               rd_en_q, rd_en_d, rd_valid_q, rd_valid_d, busy_q, busy_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [7:0]         drop_q, drop_d;
  logic               mux_sync;

  lmx2492_muxout_sync u_sync (
    .clk      (read_clk),
    .rst      (sys_rst),
    .async_in (bus.spi_muxout),
    .sync_out (mux_sync)
  );

  // State, counters and every output are registered together
  always_ff @(posedge read_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      shadow_q   <= '0;
      csb_q      <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      shadow_q   <= shadow_d;
      csb_q      <= csb_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    frame_d    = frame_q;
    shadow_d   = shadow_q;
    csb_d      = csb_q;
    sdi_d      = sdi_q;
    rd_en_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    drop_d     = drop_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: state_d = CAPTURE;
      CAPTURE: begin
        cnt_d   = '0;
        frame_d = frame_t'(bus.fifo_dout[FRAME_W-1:0]);
        if (!bus.fifo_dout[VALID_BIT]) begin
          if (drop_q != '1) drop_d = drop_q + 1'b1;
          state_d = IDLE;
        end else begin
          csb_d   = 1'b0;
          sdi_d   = bus.fifo_dout[RW_BIT];
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          bit_d   = BIT_W'(FRAME_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Last cycle of the high phase: sample readback, then advance to the next bit
        if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
          if (frame_q.rw && (bit_q < BIT_W'(DATA_W)))
            shadow_d = {shadow_q[DATA_W-2:0], mux_sync};
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q - 1'b1;
            sdi_d = frame_q[bit_d];
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          csb_d   = 1'b1;
          state_d = GAP;
          if (frame_q.rw) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = frame_q.addr;
            rd_data_d  = shadow_q;
          end
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(FRAME_GAP - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sck_d  = (state_d == SHIFT) && (cnt_d >= CNT_W'(CLK_DIV));
    busy_d = (state_d != IDLE);
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.spi_csb    = csb_q;
  assign bus.spi_sck    = sck_q;
  assign bus.spi_sdi    = sdi_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = busy_q;
  assign bus.drop_cnt   = drop_q;

endmodule
